// File: rtl/qracc_psum_accumulator.sv
// rtl/qracc_psum_accumulator.sv - bit-serial shift-accumulate of per-column ADC codes into partial sums
module qracc_psum_accumulator #(
  parameter int numCols      = 32,
  parameter int numAdcBits   = 4,
  parameter int numCfgBits   = 8,
  parameter int accBits      = 16,
  parameter int maxInputBits = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [numCfgBits-1:0]         n_input_bits_cfg,
  input  logic                          binary_cfg,
  input  logic [numCols*numAdcBits-1:0] adc_out_i,
  input  logic                          adc_valid_i,
  output logic                          adc_ready_o,
  output logic [numCols*accBits-1:0]    psum_o,
  output logic                          psum_valid_o,
  input  logic                          psum_ready_i,
  output logic                          busy_o
);

  localparam int PW = $clog2(maxInputBits + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t             state;
  logic [PW-1:0]      plane;
  logic [PW-1:0]      last_plane;
  logic               binary_q;
  logic [accBits-1:0] acc      [numCols];
  logic [accBits-1:0] term     [numCols];
  logic [accBits-1:0] next_acc [numCols];

  logic [PW-1:0] cfg_last_plane;
  logic [PW-1:0] cur_plane;
  logic [PW-1:0] cur_last;
  logic          cur_binary;
  logic          is_last;
  logic          negate;

  // Index of the final plane after clamping the requested count into 1..maxInputBits.
  always_comb begin
    cfg_last_plane = PW'(maxInputBits - 1);
    if (n_input_bits_cfg == '0) begin
      cfg_last_plane = '0;
    end else if (int'(n_input_bits_cfg) <= maxInputBits) begin
      cfg_last_plane = PW'(n_input_bits_cfg - 1'b1);
    end
  end

  // In S_IDLE the incoming beat is plane 0 and uses the live config; afterwards the latched copy.
  always_comb begin
    cur_plane  = (state == S_IDLE) ? '0 : plane;
    cur_last   = (state == S_IDLE) ? cfg_last_plane : last_plane;
    cur_binary = (state == S_IDLE) ? binary_cfg : binary_q;
    is_last    = (cur_plane == cur_last);
    negate     = cur_binary & is_last;
  end

  always_comb begin
    for (int k = 0; k < numCols; k++) begin
      term[k] = {{(accBits-numAdcBits){adc_out_i[k*numAdcBits+numAdcBits-1]}},
                 adc_out_i[k*numAdcBits +: numAdcBits]} << cur_plane;
      if (state == S_IDLE) begin
        next_acc[k] = negate ? -term[k] : term[k];
      end else begin
        next_acc[k] = negate ? (acc[k] - term[k]) : (acc[k] + term[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      plane        <= '0;
      last_plane   <= '0;
      binary_q     <= 1'b0;
      adc_ready_o  <= 1'b1;
      psum_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      for (int k = 0; k < numCols; k++) begin
        acc[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_ACC: begin
          if (adc_valid_i) begin
            acc <= next_acc;
            if (state == S_IDLE) begin
              last_plane <= cfg_last_plane;
              binary_q   <= binary_cfg;
            end
            busy_o <= 1'b1;
            if (is_last) begin
              state        <= S_OUT;
              plane        <= '0;
              adc_ready_o  <= 1'b0;
              psum_valid_o <= 1'b1;
            end else begin
              state <= S_ACC;
              plane <= cur_plane + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (psum_ready_i) begin
            state        <= S_IDLE;
            adc_ready_o  <= 1'b1;
            psum_valid_o <= 1'b0;
            busy_o       <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          plane        <= '0;
          adc_ready_o  <= 1'b1;
          psum_valid_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < numCols; k++) begin : g_psum
    assign psum_o[k*accBits +: accBits] = acc[k];
  end

endmodule

// File: doc/qracc_psum_accumulator.md
# qracc_psum_accumulator

Bit-serial partial-sum accumulator directly downstream of the QR accelerator wrapper's ADC output. The MAC array processes one input bit-plane per cycle and produces a signed `numAdcBits` code per column. This block shift-accumulates those codes over `n_input_bits_cfg` planes into a full-precision per-column partial sum. It then presents the sums on a valid/ready port to the output buffer.

## Interface
- `numCols`, 32, number of columns (lanes)
- `numAdcBits`, 4, width of each signed ADC code
- `numCfgBits`, 8, width of the configuration fields
- `accBits`, 16, width of each per-column accumulator
- `maxInputBits`, 8, largest supported number of input bit-planes
- `clk`  in  1  clock
- `nrst`  in  1  asynchronous active-low reset
- `n_input_bits_cfg`  in  numCfgBits  bit-planes per activation batch
- `binary_cfg`  in  1  1 = two's-complement inputs (MSB plane negative); 0 = ternary/bipolar, all planes positive
- `adc_out_i`  in  numCols*numAdcBits  packed signed ADC codes; column k at [k*numAdcBits +: numAdcBits]
- `adc_valid_i`  in  1  `adc_out_i` holds a valid plane
- `adc_ready_o`  out  1  block accepts a plane this cycle
- `psum_o`  out  numCols*accBits  packed signed partial sums; column k at [k*accBits +: accBits]
- `psum_valid_o`  out  1  `psum_o` holds a completed batch
- `psum_ready_i`  in  1  consumer takes `psum_o`
- `busy_o`  out  1  a batch is in progress (state ≠ S_IDLE)

## Operation
- Effective plane count N:
  - N = clamp(`n_input_bits_cfg`, 1, `maxInputBits`).
  - A value of 0 is treated as 1.
  - Values above `maxInputBits` are treated as `maxInputBits`.
- N and `binary_cfg` are latched on the first accepted beat of a batch. Changes mid-batch are ignored.
- Planes arrive LSB-first. The plane index p runs from 0 to N-1.
- Per accepted beat, for each column: term = sign-extend(adc) << p.
  - If `binary_cfg` = 1 and p = N-1, subtract the term.
  - Otherwise, add it.
  - On beat p = 0 the accumulator is loaded, not added: acc = ±term. No separate clear is needed.
- Arithmetic is two's complement, modulo 2^accBits, and wraps silently with no saturation.
- FSM:
  - **S_IDLE:** `adc_ready_o` = 1. An accepted beat latches the config and loads the accumulator with p = 0.
    - If N = 1, go to S_OUT.
    - Otherwise, set p = 1 and go to S_ACC.
  - **S_ACC:** `adc_ready_o` = 1. Each accepted beat accumulates and increments p.
    - The beat with p = N-1 goes to S_OUT.
    - Cycles with `adc_valid_i` = 0 stall with no state change.
  - **S_OUT:** `adc_ready_o` = 0 and `psum_valid_o` = 1.
    - `psum_o` is held stable until `psum_ready_i` = 1.
    - That handshake returns to S_IDLE.
- `psum_o` is driven directly from the accumulator registers. It is meaningful only while `psum_valid_o` = 1.

## Timing
- Reset values: S_IDLE, p = 0, accumulators = 0, `psum_o` = 0, `psum_valid_o` = 0, `adc_ready_o` = 1, `busy_o` = 0.
- Reset mid-batch discards the partial sum immediately, asynchronously.
- A beat is accepted on a rising edge with `adc_valid_i` & `adc_ready_o`.
- `psum_valid_o` rises in the cycle after the final accepted beat. With back-to-back beats, the latency from the first beat is N cycles.
- On the edge where `psum_valid_o` & `psum_ready_i` are both 1, the state goes to S_IDLE. `adc_ready_o` is 1 in the next cycle.
  - A beat presented in the same cycle as the output handshake is not accepted, because `adc_ready_o` = 0 in S_OUT.
  - Minimum batch period is therefore N + 1 cycles.
- `adc_ready_o` is a function of state only. It has no combinational path from `psum_ready_i` or `adc_valid_i`.
- All outputs are registered or decoded from state only.

## Test plan
- **Reset values:** assert `nrst` = 0 for 2 cycles → all outputs at their reset values, `adc_ready_o` = 1.
- **Ternary, 1 plane:** `binary_cfg` = 0, N = 1, column 0 = +3, column 1 = -2 → one cycle later `psum_valid_o` = 1 with `psum_o`[0] = 3 and [1] = -2.
- **Binary, 4 planes:**
  - Setup: `binary_cfg` = 1, N = 4, column 0 codes 1, 2, -1, 1 sent back-to-back.
  - Expected sum: 1 + 4 - 4 - 8 = -7.
  - `psum_valid_o` asserts 4 cycles after the first beat.
- **Ternary, 2 planes, with stall and backpressure:**
  - Setup: `binary_cfg` = 0, N = 2, codes 7 then 7, with `adc_valid_i` low for 3 cycles between them; hold `psum_ready_i` = 0 for 5 cycles.
  - `psum_o`[0] = 21 is stable throughout and `adc_ready_o` = 0.
  - After `psum_ready_i` pulses, `busy_o` = 0 on the next cycle.
- **Config edges and wrap:**
  - `n_input_bits_cfg` = 0 behaves as N = 1.
  - `n_input_bits_cfg` = 200 behaves as N = 8.
  - Changing `n_input_bits_cfg` mid-batch has no effect.
  - With `accBits` = 8 and N = 8, codes of 7 on every plane wrap: 7·255 mod 256 = 249, read as signed = -7.
- **Reset mid-operation:** drop `nrst` after beat 2 of 4, then run a fresh N = 1 batch with code 5 → result 5, with no residue from the aborted batch.
